// File: rtl/utmi_tx_sequencer.sv
// -----------------------------------------------------------------------------
// utmi_tx_sequencer
// Transmit-side sequencer for the UTMI NRZI encoder. Takes bytes from the SIE
// over a TxValid/TxReady handshake. Sends the SYNC field, then the data LSB-first
// with bit stuffing, then the EOP sequence. It drives the encoder's data_in,
// mode code (NRZI_en) and bit-phase counter (edge_count). One bit-time is four
// Clk cycles. The encoder consumes data_out when edge_count == 3.
// -----------------------------------------------------------------------------
module utmi_tx_sequencer #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         STUFF_LIMIT  = 6,
    parameter int         EOP_BITS     = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] DataIn,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       data_out,
    output logic [1:0] NRZI_en,
    output logic [1:0] edge_count,
    output logic       tx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } state_t;

    localparam logic [1:0] MODE_NOOP   = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b10;
    localparam logic [1:0] MODE_EOP    = 2'b01;

    localparam int                ONES_W     = $clog2(STUFF_LIMIT + 1);
    localparam logic [ONES_W-1:0] ONES_LIMIT = ONES_W'(STUFF_LIMIT);
    localparam logic [2:0]        EOP_LAST   = 3'(EOP_BITS - 1);

    // Registered state
    state_t            r_state;
    logic [1:0]        r_edge_count;
    logic              r_data_out;
    logic [1:0]        r_nrzi_en;
    logic [7:0]        r_shift;          // bit 0 is the real bit currently presented
    logic [2:0]        r_bit_idx;        // SYNC/DATA bit index, or EOP bit counter
    logic [ONES_W-1:0] r_ones_cnt;       // consecutive 1s sent so far
    logic              r_stuff_pending;  // data_out currently carries a stuff 0
    logic              r_eop_pending;    // packet ends once the stuff 0 is consumed

    // Next-state values
    state_t            w_state_nxt;
    logic [1:0]        w_edge_count_nxt;
    logic              w_data_out_nxt;
    logic [1:0]        w_nrzi_en_nxt;
    logic [7:0]        w_shift_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [ONES_W-1:0] w_ones_cnt_nxt;
    logic              w_stuff_pending_nxt;
    logic              w_eop_pending_nxt;

    logic              w_tx_ready;
    logic              w_go_eop;
    logic              w_consume;
    logic              w_last_bit;
    logic [ONES_W-1:0] w_ones_upd;

    // The encoder samples data_out on this edge, so the next bit is registered here too
    assign w_consume  = (r_state != ST_IDLE) && (r_edge_count == 2'd3);
    assign w_last_bit = (r_bit_idx == 3'd7);
    // Run length after the real bit now on data_out has been sent
    assign w_ones_upd = r_shift[0] ? (r_ones_cnt + ONES_W'(1)) : '0;

    // Next-state, next-output and handshake decode
    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        w_state_nxt         = r_state;
        w_edge_count_nxt    = (r_state == ST_IDLE) ? 2'd0 : (r_edge_count + 2'd1);
        w_data_out_nxt      = r_data_out;
        w_nrzi_en_nxt       = r_nrzi_en;
        w_shift_nxt         = r_shift;
        w_bit_idx_nxt       = r_bit_idx;
        w_ones_cnt_nxt      = r_ones_cnt;
        w_stuff_pending_nxt = r_stuff_pending;
        w_eop_pending_nxt   = r_eop_pending;
        w_tx_ready          = 1'b0;
        w_go_eop            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (TxValid) begin
                    w_state_nxt         = ST_SYNC;
                    w_nrzi_en_nxt       = MODE_NORMAL;
                    w_edge_count_nxt    = 2'd0;
                    w_data_out_nxt      = SYNC_PATTERN[0];
                    w_bit_idx_nxt       = 3'd0;
                    w_ones_cnt_nxt      = '0;
                    w_stuff_pending_nxt = 1'b0;
                    w_eop_pending_nxt   = 1'b0;
                end
            end

            ST_SYNC: begin
                if (w_consume) begin
                    if (w_last_bit) begin
                        // The trailing SYNC 1 starts the run for bit stuffing
                        w_ones_cnt_nxt = ONES_W'(1);
                        if (TxValid) begin
                            w_tx_ready     = 1'b1;
                            w_shift_nxt    = DataIn;
                            w_state_nxt    = ST_DATA;
                            w_data_out_nxt = DataIn[0];
                            w_bit_idx_nxt  = 3'd0;
                        end else begin
                            w_go_eop = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt  = r_bit_idx + 3'd1;
                        w_data_out_nxt = SYNC_PATTERN[r_bit_idx + 3'd1];
                    end
                end
            end

            ST_DATA: begin
                if (w_consume) begin
                    if (r_stuff_pending) begin
                        // Stuff 0 consumed. The next real bit is already at r_shift[0]
                        w_stuff_pending_nxt = 1'b0;
                        w_ones_cnt_nxt      = '0;
                        if (r_eop_pending) begin
                            w_go_eop = 1'b1;
                        end else begin
                            w_data_out_nxt = r_shift[0];
                        end
                    end else begin
                        w_ones_cnt_nxt = w_ones_upd;
                        // Advance to the next real bit, or accept the next byte at the boundary
                        if (w_last_bit) begin
                            if (TxValid) begin
                                w_tx_ready    = 1'b1;
                                w_shift_nxt   = DataIn;
                                w_bit_idx_nxt = 3'd0;
                            end
                        end else begin
                            w_shift_nxt   = r_shift >> 1;
                            w_bit_idx_nxt = r_bit_idx + 3'd1;
                        end
                        // Choose what goes out next: a stuff 0, the next real bit, or EOP
                        if (w_ones_upd == ONES_LIMIT) begin
                            w_stuff_pending_nxt = 1'b1;
                            w_data_out_nxt      = 1'b0;
                            w_eop_pending_nxt   = w_last_bit && !TxValid;
                        end else if (w_last_bit && !TxValid) begin
                            w_go_eop = 1'b1;
                        end else if (w_last_bit) begin
                            w_data_out_nxt = DataIn[0];
                        end else begin
                            w_data_out_nxt = r_shift[1];
                        end
                    end
                end
            end

            ST_EOP: begin
                if (w_consume) begin
                    if (r_bit_idx == EOP_LAST) begin
                        w_state_nxt      = ST_IDLE;
                        w_nrzi_en_nxt    = MODE_NOOP;
                        w_edge_count_nxt = 2'd0;
                        w_data_out_nxt   = 1'b1;
                        w_bit_idx_nxt    = 3'd0;
                    end else begin
                        // SE0 bits carry 0. The final J bit carries 1
                        w_bit_idx_nxt  = r_bit_idx + 3'd1;
                        w_data_out_nxt = ((r_bit_idx + 3'd1) == EOP_LAST);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Common entry into EOP from SYNC (empty packet) or DATA (packet end)
        if (w_go_eop) begin
            w_state_nxt         = ST_EOP;
            w_nrzi_en_nxt       = MODE_EOP;
            w_data_out_nxt      = (EOP_LAST == 3'd0);
            w_bit_idx_nxt       = 3'd0;
            w_ones_cnt_nxt      = '0;
            w_stuff_pending_nxt = 1'b0;
            w_eop_pending_nxt   = 1'b0;
        end
    end

    // State and output registers. An asynchronous reset aborts any packet
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state         <= ST_IDLE;
            r_edge_count    <= 2'd0;
            r_data_out      <= 1'b1;
            r_nrzi_en       <= MODE_NOOP;
            r_shift         <= 8'h00;
            r_bit_idx       <= 3'd0;
            r_ones_cnt      <= '0;
            r_stuff_pending <= 1'b0;
            r_eop_pending   <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            r_state         <= w_state_nxt;
            r_edge_count    <= w_edge_count_nxt;
            r_data_out      <= w_data_out_nxt;
            r_nrzi_en       <= w_nrzi_en_nxt;
            r_shift         <= w_shift_nxt;
            r_bit_idx       <= w_bit_idx_nxt;
            r_ones_cnt      <= w_ones_cnt_nxt;
            r_stuff_pending <= w_stuff_pending_nxt;
            r_eop_pending   <= w_eop_pending_nxt;
        end
    end

    assign TxReady    = w_tx_ready;
    assign data_out   = r_data_out;
    assign NRZI_en    = r_nrzi_en;
    assign edge_count = r_edge_count;
    assign tx_busy    = (r_state != ST_IDLE);

endmodule
